// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic {BOOT, RUN} state_e;

  // kill is the LSB so the outstanding queue can set it with a one-bit mask
  typedef struct packed {
    logic [31:0] addr;
    logic        kill;
  } out_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fifo_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus: req/gnt request phase, in-order rvalid response phase.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a mark input that ORs MarkMask into
// every stored entry (used to kill all in-flight fetches at once).
module fetch_fifo #(
  parameter int unsigned           Width    = 32,
  parameter int unsigned           Depth    = 2,
  parameter logic [Width-1:0]      MarkMask = '0,
  localparam int unsigned          PtrW     = $clog2(Depth),
  localparam int unsigned          CntW     = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mark,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      if (do_push && wptr_q == PtrW'(i)) begin
        mem_q[i] <= wdata;
      end else if (mark) begin
        mem_q[i] <= mem_q[i] | MarkMask;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers returned
// instructions and hands them to the decoder; redirects flush everything in flight.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  instr_fetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      op_ready,
  output logic                      op_valid,
  output logic [31:0]               I_OP,
  output logic [31:0]               op_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $bits(out_entry_t);
  localparam int unsigned BufW = $bits(fifo_entry_t);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] last_pc_q;

  out_entry_t  out_wdata, out_head;
  fifo_entry_t buf_wdata, buf_head;
  logic        out_push, out_pop, out_empty;
  logic        buf_push, buf_pop, buf_empty;
  logic [CntW-1:0] out_cnt, buf_cnt;
  logic        credit_ok, fire;

  // State register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Outputs: killed entries keep holding credit until their response drains
  assign credit_ok = (32'(out_cnt) + 32'(buf_cnt)) < DEPTH;

  always_comb begin
    imem.imem_req  = (state_q == RUN) && credit_ok;
    imem.imem_addr = fetch_pc_q;
  end

  assign fire = imem.imem_req && imem.imem_gnt;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    else if (fire)      fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= op_pc;
    end
  end

  // A fetch granted in the redirect cycle is born killed.
  always_comb begin
    out_wdata.addr = fetch_pc_q;
    out_wdata.kill = redirect_valid;
  end

  assign out_push = fire;
  assign out_pop  = imem.imem_rvalid && !out_empty && (state_q == RUN);

  fetch_fifo #(
    .Width    (OutW),
    .Depth    (DEPTH),
    .MarkMask (OutW'(1))
  ) u_outstanding (
    .clk   (clk),
    .rst   (rstn),
    .flush (1'b0),
    .mark  (redirect_valid),
    .push  (out_push),
    .wdata (out_wdata),
    .pop   (out_pop),
    .rdata (out_head),
    .empty (out_empty),
    .count (out_cnt)
  );

  always_comb begin
    buf_wdata.pc   = out_head.addr;
    buf_wdata.insn = imem.imem_rdata;
  end

  assign buf_push = out_pop && !out_head.kill && !redirect_valid;
  assign buf_pop  = op_valid && op_ready && !redirect_valid;

  fetch_fifo #(
    .Width    (BufW),
    .Depth    (DEPTH),
    .MarkMask ('0)
  ) u_insn_buf (
    .clk   (clk),
    .rst   (rstn),
    .flush (redirect_valid),
    .mark  (1'b0),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (buf_pop),
    .rdata (buf_head),
    .empty (buf_empty),
    .count (buf_cnt)
  );

  assign op_valid = !buf_empty;
  assign I_OP     = buf_empty ? NOP_INSN : buf_head.insn;
  assign op_pc    = buf_empty ? last_pc_q : buf_head.pc;

  // A response with nothing outstanding means the memory broke the protocol.
  a_rvalid_has_owner : assert property (
    @(posedge clk) disable iff (rstn)
    (imem.imem_rvalid && state_q == RUN) |-> !out_empty
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for streaming/stall, then
// hand-written redirect and mid-stream reset sequences against a simple memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        redirect_valid, op_ready, op_valid;
  logic [31:0] redirect_pc, I_OP, op_pc;

  instr_fetch_unit_if imem_bus ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .op_ready       (op_ready),
    .op_valid       (op_valid),
    .I_OP           (I_OP),
    .op_pc          (op_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  pend_t pend[$];
  vec_t  vt[21];
  int    cyc, lat, checks, failures;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the edge, memory answers `lat` cycles after gnt.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic rst);
    @(posedge clk);
    #2;
    cyc++;
    rstn           = rst;
    op_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = insn_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'h0;
    end
    @(negedge clk);
    if (imem_bus.imem_req && imem_bus.imem_gnt)
      pend.push_back('{addr: imem_bus.imem_addr, due: cyc + lat});
  endtask

  // Leaves the bench in cycle 0 (BOOT) at the sampling point.
  task automatic do_reset(input int l);
    lat                  = l;
    rstn                 = 1'b1;
    redirect_valid       = 1'b0;
    redirect_pc          = 32'h0;
    op_ready             = 1'b1;
    imem_bus.imem_gnt    = 1'b1;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    pend.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    cyc = 0;
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] pc);
    chk({tag, "_req"}, imem_bus.imem_req, req);
    chk({tag, "_addr"}, imem_bus.imem_addr, addr);
    chk({tag, "_valid"}, op_valid, vld);
    chk({tag, "_pc"}, op_pc, pc);
    chk({tag, "_insn"}, I_OP, vld ? insn_of(pc) : NOP_INSN);
  endtask

  task automatic expect_first_op(input string name, input logic [31:0] pc, input int want_n);
    int n = 0;
    do begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n++;
    end while (!op_valid && n < 30);
    chk({name, "_latency"}, n, want_n);
    chk({name, "_pc"}, op_pc, pc);
    chk({name, "_insn"}, I_OP, insn_of(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //       rdy   req   addr   vld   op_pc
    vt[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[3]  = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
    vt[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[5]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h04};
    vt[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
    vt[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    vt[8]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
    for (int i = 9; i <= 16; i++) vt[i] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
    vt[17] = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
    vt[18] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    vt[19] = '{1'b1, 1'b1, 32'h18, 1'b0, 32'h10};
    vt[20] = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h14};

    // Streaming from reset, then a 10-cycle downstream stall and resume
    do_reset(1);
    for (int i = 0; i < 21; i++) begin
      if (i != 0) drive(vt[i].rdy, 1'b0, 32'h0, 1'b0);
      check_outs($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].vld, vt[i].pc);
    end

    // Redirect with two fetches outstanding, responses 3 cycles late
    do_reset(3);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    chk("redirA_credit_full", imem_bus.imem_req, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redirA_addr", imem_bus.imem_addr, 32'h100);
    chk("redirA_killed_hold_credit", imem_bus.imem_req, 1'b0);
    chk("redirA_valid", op_valid, 1'b0);
    expect_first_op("redirA_first", 32'h100, 5);

    // Redirect in the same cycle as gnt and rvalid, unaligned target
    do_reset(1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h203, 1'b0);
    chk("redirB_gnt_same_cycle", imem_bus.imem_req & (imem_bus.imem_addr == 32'h4), 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redirB_addr", imem_bus.imem_addr, 32'h200);
    chk("redirB_req", imem_bus.imem_req, 1'b1);
    chk("redirB_valid", op_valid, 1'b0);
    expect_first_op("redirB_first", 32'h200, 2);

    // Two redirects back to back: the second one wins
    do_reset(1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    drive(1'b1, 1'b1, 32'h80, 1'b0);
    chk("redirC_first_target", imem_bus.imem_addr, 32'h40);
    expect_first_op("redirC_first", 32'h80, 3);

    // One-cycle reset mid-stream with two responses still pending
    do_reset(2);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_pre_pc", op_pc, 32'h4);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check_outs("rst_now", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check_outs("rst_boot", 1'b0, 32'h0, 1'b0, 32'h0);
    expect_first_op("rst_restart", 32'h0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
